if_fetch: RTL and testbench

//  Instruction-fetch stage: consumer of the next-PC produced by write-back.

---
 rtl/if_fetch.sv | 147 ++++++++++++++
 tb/tb_if_fetch.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/if_fetch.sv
// Instruction-fetch stage: issues word fetches over req/gnt + rvalid, buffers the
// returned words and presents {instr, pc} to decode; a redirect flushes and drops stale data.
module if_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_gnt_i,
    input  logic        imem_rvalid_i,
    input  logic [31:0] imem_rdata_i,
    output logic        instr_valid_o,
    output logic [31:0] instr_o,
    output logic [31:0] instr_pc_o,
    input  logic        instr_ready_i
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = PW + 1;

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DROP} state_t;

    state_t        r_state, w_state_next;
    logic [31:0]   r_fetch_pc, w_fetch_pc_next;
    logic [31:0]   r_hold_addr, w_hold_addr_next;
    logic          r_stale, w_stale_next;
    logic [31:0]   r_req_pc;
    logic          r_run;

    logic [31:0]   r_buf_instr [DEPTH];
    logic [31:0]   r_buf_pc    [DEPTH];
    logic [PW-1:0] r_rd_ptr, r_wr_ptr;
    logic [CW-1:0] r_count;

    logic          w_req, w_grant, w_push, w_pop, w_valid;
    logic [31:0]   w_addr;

    // In IDLE nothing is outstanding, so the credit check reduces to count < DEPTH.
    assign w_valid = (r_count != '0);
    assign w_req   = r_run && (r_state == S_IDLE) && (r_count < CW'(DEPTH));
    assign w_addr  = r_stale ? r_hold_addr : r_fetch_pc;
    assign w_grant = w_req && imem_gnt_i;
    assign w_push  = !redirect_i && (r_state == S_WAIT) && imem_rvalid_i;
    assign w_pop   = !redirect_i && w_valid && instr_ready_i;

    always_comb begin
        w_state_next     = r_state;
        w_fetch_pc_next  = r_fetch_pc;
        w_hold_addr_next = r_hold_addr;
        w_stale_next     = r_stale;
        case (r_state)
            S_IDLE: begin
                if (w_grant) begin
                    w_stale_next = 1'b0;
                    if (redirect_i || r_stale) begin
                        w_state_next = S_DROP;
                    end else begin
                        w_state_next    = S_WAIT;
                        w_fetch_pc_next = r_fetch_pc + 32'd4;
                    end
                end else if (w_req && redirect_i) begin
                    // Live request keeps its address; its eventual response is stale.
                    w_stale_next     = 1'b1;
                    w_hold_addr_next = w_addr;
                end
            end
            S_WAIT: begin
                if (imem_rvalid_i) begin
                    w_state_next = S_IDLE;
                end else if (redirect_i) begin
                    w_state_next = S_DROP;
                end
            end
            S_DROP: begin
                if (imem_rvalid_i) begin
                    w_state_next = S_IDLE;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
        if (redirect_i) begin
            w_fetch_pc_next = {redirect_pc_i[31:2], 2'b00};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_fetch_pc  <= {RESET_PC[31:2], 2'b00};
            r_hold_addr <= '0;
            r_stale     <= 1'b0;
            r_req_pc    <= '0;
            r_run       <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_fetch_pc  <= w_fetch_pc_next;
            r_hold_addr <= w_hold_addr_next;
            r_stale     <= w_stale_next;
            r_run       <= 1'b1;
            if (w_grant) begin
                r_req_pc <= w_addr;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst || redirect_i) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_buf_instr[i] <= '0;
                r_buf_pc[i]    <= '0;
            end
        end else if (w_push) begin
            r_buf_instr[r_wr_ptr] <= imem_rdata_i;
            r_buf_pc[r_wr_ptr]    <= r_req_pc;
        end
    end

    assign imem_req_o    = w_req;
    assign imem_addr_o   = w_addr;
    assign instr_valid_o = w_valid;
    assign instr_o       = r_buf_instr[r_rd_ptr];
    assign instr_pc_o    = r_buf_pc[r_rd_ptr];

endmodule

// File: tb/tb_if_fetch.sv
// Randomized bench for if_fetch: memory responder, scoreboard of the expected
// {pc, instr} stream (sequential from reset/redirect target) and directed scenarios.
module tb_if_fetch;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam int          DEPTH    = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        redirect_i = 1'b0;
    logic [31:0] redirect_pc_i = '0;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_gnt_i = 1'b0;
    logic        imem_rvalid_i = 1'b0;
    logic [31:0] imem_rdata_i = '0;
    logic        instr_valid_o;
    logic [31:0] instr_o;
    logic [31:0] instr_pc_o;
    logic        instr_ready_i = 1'b0;

    if_fetch #(.RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .redirect_i(redirect_i), .redirect_pc_i(redirect_pc_i),
        .imem_req_o(imem_req_o), .imem_addr_o(imem_addr_o),
        .imem_gnt_i(imem_gnt_i), .imem_rvalid_i(imem_rvalid_i), .imem_rdata_i(imem_rdata_i),
        .instr_valid_o(instr_valid_o), .instr_o(instr_o), .instr_pc_o(instr_pc_o),
        .instr_ready_i(instr_ready_i)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } exp_t;

    int checks = 0;
    int errors = 0;

    // responder controls and status
    int          gnt_mode = 1;   // 0 never, 1 always, 2 random
    int          lat_lo = 0, lat_hi = 0;
    logic        hold_rsp = 1'b0, release_rsp = 1'b0;
    logic        out_busy = 1'b0;
    int          out_delay = 0;
    logic [31:0] out_addr = '0;
    logic [31:0] grant_q[$];
    int          hs_count = 0;
    int          hs_cyc_q[$];
    int          cyc = 0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h0BAD_F00D;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    // Responder + scoreboard monitor, acting at the negedge for the coming posedge.
    initial begin : monitor
        logic        p_rst, p_grant, p_rvalid, p_hold;
        logic [31:0] p_addr, next_pc;
        exp_t        exp_q[$];
        exp_t        e;
        p_rst = 1'b1; p_grant = 1'b0; p_rvalid = 1'b0; p_hold = 1'b0; p_addr = '0;
        next_pc = RESET_PC;
        forever begin
            @(negedge clk);
            cyc++;
            if (p_rst) begin
                out_busy = 1'b0;
            end else begin
                if (p_rvalid) out_busy = 1'b0;
                if (p_grant) begin
                    out_busy  = 1'b1;
                    out_addr  = p_addr;
                    out_delay = $urandom_range(lat_hi, lat_lo);
                    grant_q.push_back(p_addr);
                end
            end
            if (p_hold) begin
                chk("req_held", {31'd0, imem_req_o}, 32'd1);
                chk("addr_held", imem_addr_o, p_addr);
            end
            if (imem_req_o && !rst) begin
                chk("addr_align", {30'd0, imem_addr_o[1:0]}, 32'd0);
                chk("one_outstanding", {31'd0, out_busy}, 32'd0);
            end
            imem_rvalid_i = 1'b0;
            if (!rst && out_busy) begin
                if (hold_rsp && !release_rsp) begin
                    imem_rvalid_i = 1'b0;
                end else if (hold_rsp || out_delay == 0) begin
                    imem_rvalid_i = 1'b1;
                end else begin
                    out_delay--;
                end
            end
            imem_rdata_i = imem_rvalid_i ? mem_word(out_addr) : $urandom;
            if (rst || gnt_mode == 0) imem_gnt_i = 1'b0;
            else if (gnt_mode == 1)   imem_gnt_i = 1'b1;
            else                      imem_gnt_i = ($urandom % 3) != 0;
            p_rst    = rst;
            p_grant  = imem_gnt_i && imem_req_o && !rst;
            p_addr   = imem_addr_o;
            p_rvalid = imem_rvalid_i && !rst;
            p_hold   = imem_req_o && !imem_gnt_i && !rst;
            // expected decode stream
            if (rst) begin
                exp_q.delete();
                next_pc = {RESET_PC[31:2], 2'b00};
            end else if (redirect_i) begin
                exp_q.delete();
                next_pc = {redirect_pc_i[31:2], 2'b00};
            end else if (instr_valid_o && instr_ready_i) begin
                hs_count++;
                hs_cyc_q.push_back(cyc);
                e = exp_q.pop_front();
                chk("instr_pc", instr_pc_o, e.pc);
                chk("instr", instr_o, e.instr);
                $display("accept pc=%h instr=%h", instr_pc_o, instr_o);
            end
            while (exp_q.size() < 4) begin
                exp_q.push_back({next_pc, mem_word(next_pc)});
                next_pc = next_pc + 32'd4;
            end
        end
    end

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_req"}, {31'd0, imem_req_o}, 32'd0);
        chk({tag, "_valid"}, {31'd0, instr_valid_o}, 32'd0);
        chk({tag, "_instr"}, instr_o, 32'd0);
        chk({tag, "_pc"}, instr_pc_o, 32'd0);
    endtask

    initial begin : stim
        logic [31:0] a0;
        int          hs_base;
        // 1: reset release, zero-wait memory, ready=1
        instr_ready_i = 1'b1;
        gnt_mode = 1; lat_lo = 0; lat_hi = 0;
        repeat (3) step();
        check_reset_outputs("reset");
        grant_q.delete();
        hs_cyc_q.delete();
        rst = 1'b0;
        step();
        chk("first_req", {31'd0, imem_req_o}, 32'd1);
        chk("first_addr", imem_addr_o, RESET_PC);
        for (int i = 0; i < 100 && hs_cyc_q.size() < 4; i++) step();
        chk("p1_progress", {31'd0, hs_cyc_q.size() >= 4}, 32'd1);
        if (grant_q.size() >= 3) begin
            chk("p1_addr0", grant_q[0], 32'h0);
            chk("p1_addr1", grant_q[1], 32'h4);
            chk("p1_addr2", grant_q[2], 32'h8);
        end
        if (hs_cyc_q.size() >= 4) chk("p1_rate", hs_cyc_q[3] - hs_cyc_q[2], 32'd2);

        // 2: decode stalls, buffer fills to DEPTH, then drains in order
        instr_ready_i = 1'b0;
        repeat (10) step();
        chk("p2_req_idle", {31'd0, imem_req_o}, 32'd0);
        chk("p2_valid", {31'd0, instr_valid_o}, 32'd1);
        chk("p2_no_outstanding", {31'd0, out_busy}, 32'd0);
        grant_q.delete();
        instr_ready_i = 1'b1;
        step();
        chk("p2_drain_valid", {31'd0, instr_valid_o}, 32'd1);
        for (int i = 0; i < 50 && grant_q.size() < 1; i++) step();
        chk("p2_resume", {31'd0, grant_q.size() >= 1}, 32'd1);

        // 3: redirect while waiting for a response
        lat_lo = 3; lat_hi = 3;
        for (int i = 0; i < 100 && !(out_busy && out_delay >= 2); i++) step();
        chk("p3_wait_timeout", {31'd0, out_busy && out_delay >= 2}, 32'd1);
        grant_q.delete();
        redirect_i = 1'b1; redirect_pc_i = 32'h100;
        step();
        redirect_i = 1'b0;
        for (int i = 0; i < 50 && grant_q.size() < 1; i++) step();
        chk("p3_grant_timeout", {31'd0, grant_q.size() >= 1}, 32'd1);
        if (grant_q.size() >= 1) chk("p3_addr", grant_q[0], 32'h100);

        // 4: redirect while the request is held without grant
        lat_lo = 0; lat_hi = 0; gnt_mode = 0;
        for (int i = 0; i < 100 && !imem_req_o; i++) step();
        chk("p4_req_timeout", {31'd0, imem_req_o}, 32'd1);
        a0 = imem_addr_o;
        grant_q.delete();
        redirect_i = 1'b1; redirect_pc_i = 32'h203;
        step();
        redirect_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("p4_req_live", {31'd0, imem_req_o}, 32'd1);
            chk("p4_addr_stable", imem_addr_o, a0);
            step();
        end
        gnt_mode = 1;
        for (int i = 0; i < 50 && grant_q.size() < 2; i++) step();
        chk("p4_grant_timeout", {31'd0, grant_q.size() >= 2}, 32'd1);
        if (grant_q.size() >= 2) begin
            chk("p4_stale_addr", grant_q[0], a0);
            chk("p4_new_addr", grant_q[1], 32'h200);
        end

        // 5: redirect coincident with rvalid and pop while the buffer holds its credit
        instr_ready_i = 1'b0; lat_lo = 3; lat_hi = 3;
        for (int i = 0; i < 100 && !(instr_valid_o && out_busy && out_delay >= 2); i++) step();
        chk("p5_setup_timeout", {31'd0, instr_valid_o && out_busy && out_delay >= 2}, 32'd1);
        hold_rsp = 1'b1;
        step();
        step();
        grant_q.delete();
        redirect_i = 1'b1; redirect_pc_i = 32'h300; instr_ready_i = 1'b1; release_rsp = 1'b1;
        step();
        chk("p5_flushed", {31'd0, instr_valid_o}, 32'd0);
        redirect_i = 1'b0; hold_rsp = 1'b0; release_rsp = 1'b0;
        for (int i = 0; i < 50 && grant_q.size() < 1; i++) step();
        chk("p5_grant_timeout", {31'd0, grant_q.size() >= 1}, 32'd1);
        if (grant_q.size() >= 1) chk("p5_addr", grant_q[0], 32'h300);

        // 6: fetch PC wrap, then reset in the middle of a wait
        lat_lo = 2; lat_hi = 2;
        for (int i = 0; i < 100 && !(out_busy && out_delay >= 1); i++) step();
        chk("p6_wait_timeout", {31'd0, out_busy && out_delay >= 1}, 32'd1);
        grant_q.delete();
        redirect_i = 1'b1; redirect_pc_i = 32'hFFFF_FFFC;
        step();
        redirect_i = 1'b0;
        for (int i = 0; i < 50 && grant_q.size() < 2; i++) step();
        chk("p6_grant_timeout", {31'd0, grant_q.size() >= 2}, 32'd1);
        if (grant_q.size() >= 2) begin
            chk("p6_addr_top", grant_q[0], 32'hFFFF_FFFC);
            chk("p6_addr_wrap", grant_q[1], 32'h0);
        end
        lat_lo = 3; lat_hi = 3;
        for (int i = 0; i < 100 && !(out_busy && out_delay >= 1); i++) step();
        chk("p6_rst_setup_timeout", {31'd0, out_busy && out_delay >= 1}, 32'd1);
        rst = 1'b1;
        step();
        check_reset_outputs("midrst");
        rst = 1'b0;
        step();
        chk("midrst_req_after", {31'd0, imem_req_o}, 32'd1);
        chk("midrst_addr_after", imem_addr_o, RESET_PC);

        // randomized traffic
        hs_base = hs_count;
        gnt_mode = 2; lat_lo = 0; lat_hi = 3;
        for (int i = 0; i < 2500; i++) begin
            instr_ready_i = ($urandom % 10) < 7;
            redirect_i    = ($urandom % 40) == 0;
            redirect_pc_i = ($urandom % 4 == 0) ? (32'hFFFF_FFF0 | ($urandom % 16)) : $urandom;
            rst           = ($urandom % 500) == 0;
            step();
        end
        rst = 1'b0; redirect_i = 1'b0; instr_ready_i = 1'b1;
        repeat (30) step();
        chk("rand_progress", {31'd0, (hs_count - hs_base) >= 100}, 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
